serial_addsub_sched: RTL
========================

Name: serial_addsub_sched

Overview:
- Two-client scheduler and sequencer for one shared bit-serial add/subtract datapath: a single full-adder cell plus a carry flop.
- Arbitrates between two requesters round-robin and captures the granted operands.
- Shifts the operands LSB-first through the adder over WIDTH cycles, then returns a WIDTH-bit result with carry-out and signed overflow.
- Sits between FPU mantissa/exponent control and the gate-level arithmetic cells. It trades latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits (minimum 2).

Ports:
- CLK  input  1  clock, rising-edge.
- CLRB  input  1  reset, synchronous, active-low.
- req0  input  1  client 0 request; held high until gnt0.
- a0  input  WIDTH  client 0 operand A.
- b0  input  WIDTH  client 0 operand B.
- sub0  input  1  client 0 op: 1 = A-B, 0 = A+B.
- req1  input  1  client 1 request.
- a1  input  WIDTH  client 1 operand A.
- b1  input  WIDTH  client 1 operand B.
- sub1  input  1  client 1 op select.
- gnt  output  2  one-hot grant pulse, one cycle.
- done  output  2  one-hot completion pulse, one cycle, to the owning client.
- busy  output  1  high from the grant cycle through the done cycle.
- result  output  WIDTH  sum/difference; valid in the done cycle, held until next load.
- cout  output  1  carry-out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Clock and reset: one clock CLK. Reset CLRB is synchronous, active-low.
- Reset values: state=IDLE; gnt=0, done=0, busy=0; result=0, cout=0, ovf=0; count=0; round-robin pointer favours client 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Requests are sampled at each edge.
  - If only reqN is high, grant N.
  - If both are high, grant the client not served last; after reset, client 0.
  - On grant: load a_sr=aN, b_sr=bN, op=subN; carry flop = subN (carry-in 1 for subtract); count=0.
  - Next cycle: state=SHIFT, gnt[N]=1, busy=1.
- SHIFT, each cycle:
  - bit = FA(a_sr[0], b_sr[0] XOR op, carry).
  - The sum bit shifts into the result shift register from the MSB side; a_sr and b_sr shift right; carry updates; count++.
  - On the last bit (count=WIDTH-1), latch the carry-in as c_msb_in.
  - After WIDTH cycles, go to DONE.
  - gnt is high only in the first SHIFT cycle.
- DONE (one cycle):
  - result = shift register; cout = carry; ovf = c_msb_in XOR carry.
  - done[owner]=1; pointer records owner; next state IDLE.
- Latency: done rises exactly WIDTH+1 cycles after gnt rises. Minimum issue interval is WIDTH+2 cycles, because IDLE lasts at least one cycle.
- Requests seen outside IDLE are ignored; they must still be held and are arbitrated in the next IDLE.
- A request that rises in the DONE cycle is granted at the following IDLE edge.
- Operands are sampled only at the grant edge; later input changes have no effect.
- result, cout and ovf hold their value after DONE until the next DONE.
- Reset mid-operation: all state returns to reset values at that edge; no done is issued for the aborted operation; the pointer returns to favour client 0.
- count width: clog2(WIDTH+1).

Decomposition:
- Package serial_sched_pkg holds: the state enum (IDLE/SHIFT/DONE), the client-index type, and the constant RR_RESET=0.
- One sub-module, serial_add_slice: one full adder plus the carry flop with synchronous load.
  - Inputs: a_bit, b_bit, inv_b, load, load_val, en.
  - Outputs: sum_bit, carry, carry_in_q.
- Arbitration, FSM, shift registers and counter stay in the top module.

Test Plan (WIDTH=16):
- Add: req0 with a0=0x1234, b0=0x0FF0, sub0=0 -> gnt=01; done=01 exactly 17 cycles later; result=0x2224, cout=0, ovf=0.
- Subtract with borrow: req1 with a1=0x0005, b1=0x0007, sub1=1 -> result=0xFFFE, cout=0, ovf=0.
- Overflow:
  - 0x7FFF+0x0001 -> result=0x8000, ovf=1, cout=0.
  - 0x8000-0x0001 -> result=0x7FFF, ovf=1, cout=1.
  - 0xFFFF+0x0001 -> result=0x0000, cout=1, ovf=0.
- Contention: req0 and req1 both held high from reset -> grants 01, 10, 01, 10. Each done one-hot matches its grant; busy low for exactly one cycle between operations.
- Operand stability: change a0 to 0xFFFF one cycle after gnt0 -> result still reflects the value sampled at grant.
- Reset mid-operation: CLRB low for one edge during SHIFT cycle 5 -> next cycle all outputs 0, no done pulse. A subsequent simultaneous req0/req1 grants client 0 first.

Source files
------------

// File: rtl/serial_addsub_sched_pkg.sv
// Shared types for the two-client bit-serial add/subtract scheduler:
// FSM states, client index and round-robin reset value.
package serial_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic client_t;

  localparam client_t CLIENT0  = 1'b0;
  localparam client_t CLIENT1  = 1'b1;
  localparam client_t RR_RESET = CLIENT0;

  // One-hot encoding of a client index onto the gnt/done buses
  function automatic logic [1:0] client_onehot(input client_t c);
    logic [1:0] oh;
    oh = 2'b00;
    case (c)
      CLIENT0: oh = 2'b01;
      CLIENT1: oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/serial_addsub_sched_slice.sv
// One full-adder cell with its carry flop; also keeps the carry that fed
// the most recent bit so the top can form signed overflow after the MSB.
module serial_add_slice (
  input  logic clk,
  input  logic clrb,
  input  logic a_bit,
  input  logic b_bit,
  input  logic inv_b,
  input  logic load,
  input  logic load_val,
  input  logic en,
  output logic sum_bit,
  output logic carry,
  output logic carry_in_q
);

  logic carry_r;
  logic carry_in_r;
  logic b_eff_s;
  logic fa_cout_s;

  assign b_eff_s    = b_bit ^ inv_b;
  assign sum_bit    = a_bit ^ b_eff_s ^ carry_r;
  assign fa_cout_s  = (a_bit & b_eff_s) | (carry_r & (a_bit ^ b_eff_s));
  assign carry      = carry_r;
  assign carry_in_q = carry_in_r;

  // Carry flop: preset on load (carry-in 1 for subtract), advance per bit
  always_ff @(posedge clk) begin
    if (!clrb) begin
      carry_r    <= 1'b0;
      carry_in_r <= 1'b0;
    end else if (load) begin
      carry_r    <= load_val;
      carry_in_r <= 1'b0;
    end else if (en) begin
      carry_r    <= fa_cout_s;
      carry_in_r <= carry_r;
    end else begin
      carry_r    <= carry_r;
      carry_in_r <= carry_in_r;
    end
  end

endmodule

// File: rtl/serial_addsub_sched.sv
// Round-robin scheduler for two clients sharing one bit-serial adder.
// Operands are captured at grant and shifted LSB-first over WIDTH cycles.
module serial_addsub_sched
  import serial_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             CLRB,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             sub0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             op_r;
  client_t          owner_r;
  client_t          favour_r;
  logic [CNT_W-1:0] count_r;

  logic             grant_s;
  client_t          sel_s;
  logic             sel_sub_s;
  logic             sum_bit_s;
  logic             carry_s;
  logic             c_msb_in_s;

  // Arbitration: a lone request wins, a tie goes to the favoured client
  always_comb begin
    grant_s = 1'b0;
    sel_s   = favour_r;
    if (state_r == IDLE) begin
      if (req0 && req1) begin
        grant_s = 1'b1;
        sel_s   = favour_r;
      end else if (req0) begin
        grant_s = 1'b1;
        sel_s   = CLIENT0;
      end else if (req1) begin
        grant_s = 1'b1;
        sel_s   = CLIENT1;
      end else begin
        grant_s = 1'b0;
        sel_s   = favour_r;
      end
    end else begin
      grant_s = 1'b0;
      sel_s   = favour_r;
    end
  end

  assign sel_sub_s = (sel_s == CLIENT1) ? sub1 : sub0;

  serial_add_slice u_slice (
    .clk        (CLK),
    .clrb       (CLRB),
    .a_bit      (a_sr_r[0]),
    .b_bit      (b_sr_r[0]),
    .inv_b      (op_r),
    .load       (grant_s),
    .load_val   (sel_sub_s),
    .en         (state_r == SHIFT),
    .sum_bit    (sum_bit_s),
    .carry      (carry_s),
    .carry_in_q (c_msb_in_s)
  );

  // Sequencer: grant/load, WIDTH shift cycles, then publish the result
  always_ff @(posedge CLK) begin
    if (!CLRB) begin
      state_r  <= IDLE;
      a_sr_r   <= {WIDTH{1'b0}};
      b_sr_r   <= {WIDTH{1'b0}};
      res_sr_r <= {WIDTH{1'b0}};
      op_r     <= 1'b0;
      owner_r  <= RR_RESET;
      favour_r <= RR_RESET;
      count_r  <= {CNT_W{1'b0}};
      gnt      <= 2'b00;
      done     <= 2'b00;
      busy     <= 1'b0;
      result   <= {WIDTH{1'b0}};
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            a_sr_r  <= (sel_s == CLIENT1) ? a1 : a0;
            b_sr_r  <= (sel_s == CLIENT1) ? b1 : b0;
            op_r    <= sel_sub_s;
            owner_r <= sel_s;
            count_r <= {CNT_W{1'b0}};
            gnt     <= client_onehot(sel_s);
            busy    <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_sr_r <= {sum_bit_s, res_sr_r[WIDTH-1:1]};
          count_r  <= count_r + CNT_W'(1);
          if (count_r == CNT_W'(WIDTH - 1)) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          result   <= res_sr_r;
          cout     <= carry_s;
          ovf      <= c_msb_in_s ^ carry_s;
          done     <= client_onehot(owner_r);
          favour_r <= ~owner_r;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
